usrt_rx_deframer: RTL and testbench

//  Receive-side deframer of the USRT, directly upstream of rxparity.

---
 rtl/usrt_rx_deframer.sv | 147 ++++++++++++++
 tb/tb_usrt_rx_deframer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/usrt_rx_deframer.sv
// usrt_rx_deframer: receive-side deframer of the USRT.
// Samples the serial line on bit-time strobes, assembles start/data/parity/stop
// into one frame word, and hands it off through a one-entry valid/ready register.
// A frame that completes while the register still holds an unconsumed frame is
// dropped and flagged with a one-cycle overrun pulse.

module usrt_rx_deframer #(
    parameter int DATA_BITS = 8
) (
    input  logic                 i_Pclk,
    input  logic                 i_Rst,
    input  logic                 i_SampleEn,
    input  logic                 i_Rx,
    input  logic [1:0]           i_Parity,
    output logic [DATA_BITS+2:0] o_Frame,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic                 o_FrameErr,
    output logic                 o_Overrun,
    output logic                 o_Busy
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   data_sr;
    logic                   parity_bit;
    logic                   parity_en;
    logic                   complete;
    logic                   load;
    logic [DATA_BITS+2:0]   new_frame;

    // The stop bit is taken straight from the line so the frame is ready at the stop-strobe edge.
    assign new_frame = {i_Rx, parity_bit, data_sr, 1'b0};

    // A completed frame enters the output register only if it is empty or being drained now.
    assign load = complete && (!o_Valid || i_Ready);

    // FSM state register.
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; every transition is gated by a bit-time strobe.
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_SampleEn && !i_Rx) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (i_SampleEn && (bit_cnt == LAST_BIT)) begin
                    state_next = parity_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (i_SampleEn) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (i_SampleEn) begin
                    complete   = 1'b1;
                    state_next = i_Rx ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (i_SampleEn && i_Rx) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Frame assembly: data shifts in LSB-first, parity mode is frozen at the start bit.
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            bit_cnt    <= '0;
            data_sr    <= '0;
            parity_bit <= 1'b0;
            parity_en  <= 1'b0;
        end else if (i_SampleEn) begin
            case (state)
                S_IDLE: begin
                    if (!i_Rx) begin
                        bit_cnt    <= '0;
                        data_sr    <= '0;
                        parity_bit <= 1'b0;
                        parity_en  <= i_Parity[0] ^ i_Parity[1];
                    end
                end
                S_DATA: begin
                    data_sr <= {i_Rx, data_sr[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + CW'(1);
                end
                S_PARITY: begin
                    parity_bit <= i_Rx;
                end
                default: begin
                end
            endcase
        end
    end

    // One-entry output register with handshake, overrun pulse and registered busy flag.
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Frame    <= '0;
            o_FrameErr <= 1'b0;
            o_Valid    <= 1'b0;
            o_Overrun  <= 1'b0;
            o_Busy     <= 1'b0;
        end else begin
            if (load) begin
                o_Frame    <= new_frame;
                o_FrameErr <= ~i_Rx;
                o_Valid    <= 1'b1;
            end else if (o_Valid && i_Ready) begin
                o_Valid <= 1'b0;
            end
            o_Overrun <= complete && o_Valid && !i_Ready;
            o_Busy    <= (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_usrt_rx_deframer.sv
// tb_usrt_rx_deframer: directed bench for the USRT receive deframer.
// Serial sequences are written as the frame word itself, sent LSB-first.

module tb_usrt_rx_deframer;

    logic        i_Pclk;
    logic        i_Rst;
    logic        i_SampleEn;
    logic        i_Rx;
    logic [1:0]  i_Parity;
    logic [10:0] o_Frame;
    logic        o_Valid;
    logic        i_Ready;
    logic        o_FrameErr;
    logic        o_Overrun;
    logic        o_Busy;

    int assertCount;
    int failCount;

    usrt_rx_deframer #(.DATA_BITS(8)) dut (
        .i_Pclk     (i_Pclk),
        .i_Rst      (i_Rst),
        .i_SampleEn (i_SampleEn),
        .i_Rx       (i_Rx),
        .i_Parity   (i_Parity),
        .o_Frame    (o_Frame),
        .o_Valid    (o_Valid),
        .i_Ready    (i_Ready),
        .o_FrameErr (o_FrameErr),
        .o_Overrun  (o_Overrun),
        .o_Busy     (o_Busy)
    );

    // 100 MHz clock.
    initial begin
        i_Pclk = 1'b0;
        forever #5 i_Pclk = ~i_Pclk;
    end

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge i_Pclk);
        #1;
    endtask

    // Send n line bits LSB-first, one strobe each, with gap idle clocks after each strobe.
    task automatic applyStimulus(input logic [15:0] bits, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            i_Rx       = bits[i];
            i_SampleEn = 1'b1;
            tick();
            i_SampleEn = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
            end
        end
        i_SampleEn = 1'b0;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed scenarios.
    initial begin
        assertCount = 0;
        failCount   = 0;
        i_Rst       = 1'b1;
        i_SampleEn  = 1'b0;
        i_Rx        = 1'b1;
        i_Parity    = 2'b00;
        i_Ready     = 1'b0;

        tick();
        tick();
        checkOutput("rst_frame", 16'(o_Frame), 16'h000);
        checkOutput("rst_valid", 16'(o_Valid), 16'h0);
        checkOutput("rst_busy", 16'(o_Busy), 16'h0);
        i_Rst = 1'b0;
        tick();
        checkOutput("rel_valid", 16'(o_Valid), 16'h0);
        checkOutput("rel_overrun", 16'(o_Overrun), 16'h0);
        checkOutput("rel_ferr", 16'(o_FrameErr), 16'h0);

        // Scenario 1: parity frame 0x54A, consumer ready.
        $display("[TB] parity frame A5");
        i_Parity = 2'b01;
        i_Ready  = 1'b1;
        applyStimulus(16'h0000, 1, 0);
        checkOutput("s1_busy_start", 16'(o_Busy), 16'h1);
        applyStimulus(16'h02A5, 9, 0);
        checkOutput("s1_valid_before_stop", 16'(o_Valid), 16'h0);
        applyStimulus(16'h0001, 1, 0);
        checkOutput("s1_valid", 16'(o_Valid), 16'h1);
        checkOutput("s1_frame", 16'(o_Frame), 16'h054A);
        checkOutput("s1_ferr", 16'(o_FrameErr), 16'h0);
        checkOutput("s1_busy_end", 16'(o_Busy), 16'h0);
        tick();
        checkOutput("s1_valid_drop", 16'(o_Valid), 16'h0);

        // Scenario 2: no-parity frame 0x3C, ten strobes.
        $display("[TB] no-parity frame 3C");
        i_Parity = 2'b00;
        applyStimulus(16'h0278, 9, 0);
        checkOutput("s2_valid_9", 16'(o_Valid), 16'h0);
        applyStimulus(16'h0001, 1, 0);
        checkOutput("s2_valid_10", 16'(o_Valid), 16'h1);
        checkOutput("s2_frame", 16'(o_Frame), 16'h0478);
        tick();
        checkOutput("s2_valid_drop", 16'(o_Valid), 16'h0);

        // Scenario 3: overrun while the consumer stalls.
        $display("[TB] overrun");
        i_Ready = 1'b0;
        applyStimulus(16'h0222, 10, 0);
        checkOutput("s3_valid_a", 16'(o_Valid), 16'h1);
        checkOutput("s3_frame_a", 16'(o_Frame), 16'h0422);
        checkOutput("s3_ovr_a", 16'(o_Overrun), 16'h0);
        applyStimulus(16'h0244, 10, 0);
        checkOutput("s3_ovr_b", 16'(o_Overrun), 16'h1);
        checkOutput("s3_frame_kept", 16'(o_Frame), 16'h0422);
        checkOutput("s3_valid_kept", 16'(o_Valid), 16'h1);
        tick();
        checkOutput("s3_ovr_pulse_end", 16'(o_Overrun), 16'h0);
        i_Ready = 1'b1;
        tick();
        checkOutput("s3_valid_drained", 16'(o_Valid), 16'h0);

        // Scenario 4: stop bit 0, break hold, recovery.
        $display("[TB] framing error and break");
        applyStimulus(16'h00B4, 10, 0);
        checkOutput("s4_valid", 16'(o_Valid), 16'h1);
        checkOutput("s4_frame", 16'(o_Frame), 16'h00B4);
        checkOutput("s4_ferr", 16'(o_FrameErr), 16'h1);
        checkOutput("s4_busy_break", 16'(o_Busy), 16'h1);
        applyStimulus(16'h0000, 5, 0);
        checkOutput("s4_no_start_valid", 16'(o_Valid), 16'h0);
        checkOutput("s4_still_break", 16'(o_Busy), 16'h1);
        applyStimulus(16'h0001, 1, 0);
        checkOutput("s4_idle", 16'(o_Busy), 16'h0);
        applyStimulus(16'h0202, 10, 0);
        checkOutput("s4_new_valid", 16'(o_Valid), 16'h1);
        checkOutput("s4_new_frame", 16'(o_Frame), 16'h0402);
        checkOutput("s4_new_ferr", 16'(o_FrameErr), 16'h0);
        tick();

        // Scenario 5: reset mid-frame with a frame pending.
        $display("[TB] reset mid-frame");
        i_Parity = 2'b01;
        i_Ready  = 1'b0;
        applyStimulus(16'h061E, 11, 0);
        checkOutput("s5_pending_frame", 16'(o_Frame), 16'h061E);
        applyStimulus(16'h054A, 5, 0);
        checkOutput("s5_busy_mid", 16'(o_Busy), 16'h1);
        i_Rst = 1'b1;
        #1;
        checkOutput("s5_rst_frame", 16'(o_Frame), 16'h000);
        checkOutput("s5_rst_valid", 16'(o_Valid), 16'h0);
        checkOutput("s5_rst_busy", 16'(o_Busy), 16'h0);
        #1;
        i_Rst   = 1'b0;
        i_Ready = 1'b1;
        tick();
        applyStimulus(16'h054A, 11, 0);
        checkOutput("s5_after_valid", 16'(o_Valid), 16'h1);
        checkOutput("s5_after_frame", 16'(o_Frame), 16'h054A);
        tick();

        // Scenario 6: 1-in-4 strobes, drain and refill at the same edge.
        $display("[TB] gated strobes back-to-back");
        i_Parity = 2'b00;
        i_Ready  = 1'b0;
        applyStimulus(16'h0386, 10, 3);
        checkOutput("s6_x_valid", 16'(o_Valid), 16'h1);
        checkOutput("s6_x_frame", 16'(o_Frame), 16'h0586);
        applyStimulus(16'h0102, 9, 3);
        checkOutput("s6_x_held", 16'(o_Frame), 16'h0586);
        i_Ready = 1'b1;
        applyStimulus(16'h0001, 1, 0);
        checkOutput("s6_y_valid", 16'(o_Valid), 16'h1);
        checkOutput("s6_y_frame", 16'(o_Frame), 16'h0502);
        checkOutput("s6_y_ovr", 16'(o_Overrun), 16'h0);
        tick();
        checkOutput("s6_y_drained", 16'(o_Valid), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
